// File: rtl/mips_wb_pkg.sv
// mips_wb_pkg
//   Shared constants for the write-back stage.
//   LD_*   : load-size encodings driven by the MEM/WB latch (2'b10 behaves as word)
//   NREGS  : register count for the default 5-bit register address
package mips_wb_pkg;

  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b11;

  localparam int RNBITS_DEFAULT = 5;
  localparam int NREGS          = 2 ** RNBITS_DEFAULT;

endpackage

// File: rtl/writeback_unit_load_filter.sv
// load_filter
//   Extracts a byte, halfword or word from an aligned memory word and
//   extends it to the datapath width.
// Ports
//   raw      in  NBITS  aligned word read from data memory
//   offset   in  2      byte offset inside the word (little-endian lanes)
//   size     in  2      LD_BYTE / LD_HALF / anything else = word
//   zero_ext in  1      1 = zero-extend byte/half, 0 = sign-extend
//   data     out NBITS  filtered load value
module load_filter
  import mips_wb_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic [NBITS-1:0] raw,
  input  logic [1:0]       offset,
  input  logic [1:0]       size,
  input  logic             zero_ext,
  output logic [NBITS-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        byte_fill;
  logic        half_fill;

  always_comb begin
    byte_lane = raw[7:0];
    case (offset)
      2'd0: byte_lane = raw[7:0];
      2'd1: byte_lane = raw[15:8];
      2'd2: byte_lane = raw[23:16];
      2'd3: byte_lane = raw[31:24];
      default: byte_lane = raw[7:0];
    endcase
  end

  // Misaligned halves ignore offset[0]; only the upper/lower lane matters.
  assign half_lane = offset[1] ? raw[31:16] : raw[15:0];

  assign byte_fill = ~zero_ext & byte_lane[7];
  assign half_fill = ~zero_ext & half_lane[15];

  always_comb begin
    data = raw;
    case (size)
      LD_BYTE: data = {{(NBITS-8){byte_fill}}, byte_lane};
      LD_HALF: data = {{(NBITS-16){half_fill}}, half_lane};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit
//   WB side of the MEM/WB latch: filters load data, selects the write-back
//   value, owns the register file, and keeps a sticky halt flag and a
//   saturating retired-instruction counter. State only moves when i_step=1.
// Ports
//   i_clk, i_reset(async, active-low), i_step   clocking / advance enable
//   i_instruction, i_pc8, i_ALU, i_DatoMemoria, i_RegistroDestino, i_Extension
//   i_JAL, i_LUI, i_MemToReg, i_RegWrite, i_ZeroExtend, i_HALT, i_TamanoFiltroL
//   i_rs_addr, i_rt_addr -> o_rs_data, o_rt_data  ID reads with write bypass
//   i_dbg_addr -> o_dbg_data                       raw register file read
//   o_wb_data, o_wb_reg, o_wb_en                   forwarding information
//   o_halted, o_retired                            status
module writeback_unit
  import mips_wb_pkg::*;
#(
  parameter int NBITS   = 32,
  parameter int RNBITS  = 5,
  parameter int CNTBITS = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_step,
  input  logic [NBITS-1:0]   i_instruction,
  input  logic [NBITS-1:0]   i_pc8,
  input  logic [NBITS-1:0]   i_ALU,
  input  logic [NBITS-1:0]   i_DatoMemoria,
  input  logic [RNBITS-1:0]  i_RegistroDestino,
  input  logic [NBITS-1:0]   i_Extension,
  input  logic               i_JAL,
  input  logic               i_LUI,
  input  logic               i_MemToReg,
  input  logic               i_RegWrite,
  input  logic               i_ZeroExtend,
  input  logic               i_HALT,
  input  logic [1:0]         i_TamanoFiltroL,
  input  logic [RNBITS-1:0]  i_rs_addr,
  input  logic [RNBITS-1:0]  i_rt_addr,
  input  logic [RNBITS-1:0]  i_dbg_addr,
  output logic [NBITS-1:0]   o_rs_data,
  output logic [NBITS-1:0]   o_rt_data,
  output logic [NBITS-1:0]   o_wb_data,
  output logic [RNBITS-1:0]  o_wb_reg,
  output logic               o_wb_en,
  output logic [NBITS-1:0]   o_dbg_data,
  output logic               o_halted,
  output logic [CNTBITS-1:0] o_retired
);

  localparam int NUM_REGS = 2 ** RNBITS;

  logic [NBITS-1:0]   regs_reg [NUM_REGS];
  logic               halted_reg;
  logic [CNTBITS-1:0] retired_reg;
  logic [NBITS-1:0]   load_data;
  logic [NBITS-1:0]   wb_data;
  logic               wb_en;
  logic               commit;

  load_filter #(
    .NBITS(NBITS)
  ) u_load_filter (
    .raw     (i_DatoMemoria),
    .offset  (i_ALU[1:0]),
    .size    (i_TamanoFiltroL),
    .zero_ext(i_ZeroExtend),
    .data    (load_data)
  );

  always_comb begin
    wb_data = i_ALU;
    if (i_JAL) begin
      wb_data = i_pc8;
    end else if (i_LUI) begin
      wb_data = {i_Extension[15:0], 16'h0000};
    end else if (i_MemToReg) begin
      wb_data = load_data;
    end
  end

  // Destination 0 is filtered here, so r0 never receives a write.
  assign wb_en  = i_RegWrite & (i_RegistroDestino != '0) & ~halted_reg;
  assign commit = i_step & wb_en;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (commit) begin
      regs_reg[i_RegistroDestino] <= wb_data;
    end
  end

  // The HALT instruction itself still commits and counts: both use the
  // pre-edge value of halted_reg.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      halted_reg  <= 1'b0;
      retired_reg <= '0;
    end else if (i_step && !halted_reg) begin
      if (i_HALT) begin
        halted_reg <= 1'b1;
      end
      if ((i_instruction != '0) && (retired_reg != '1)) begin
        retired_reg <= retired_reg + CNTBITS'(1);
      end
    end
  end

  // Two ID read ports, write-first against the value committing this edge.
  logic [1:0][RNBITS-1:0] rd_addr;
  logic [1:0][NBITS-1:0]  rd_data;

  assign rd_addr[0] = i_rs_addr;
  assign rd_addr[1] = i_rt_addr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
      assign rd_data[gi] = (rd_addr[gi] == '0)                          ? '0      :
                           (commit && rd_addr[gi] == i_RegistroDestino) ? wb_data :
                                                                          regs_reg[rd_addr[gi]];
    end
  endgenerate

  assign o_rs_data  = rd_data[0];
  assign o_rt_data  = rd_data[1];
  assign o_wb_data  = wb_data;
  assign o_wb_reg   = i_RegistroDestino;
  assign o_wb_en    = wb_en;
  assign o_dbg_data = regs_reg[i_dbg_addr];
  assign o_halted   = halted_reg;
  assign o_retired  = retired_reg;

endmodule
